// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and data-memory responder state type
package cpu_pkg;

  localparam int WORD_W        = 32;
  localparam int BYTE_LANE_MSB = 31;
  localparam int BYTE_LANE_LSB = 24;
  localparam int BYTE_W        = BYTE_LANE_MSB - BYTE_LANE_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between CPU datapath and data memory
interface dmem_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - 2**ADDR_W x 32 register-file storage, async clear,
// synchronous word/byte-lane write, combinational read
module dmem_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_byte,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      // A byte store lands in the top lane; the lower 24 bits are preserved.
      if (i_byte) begin
        r_mem[i_addr][BYTE_LANE_MSB:BYTE_LANE_LSB] <= i_wdata[BYTE_W-1:0];
      end else begin
        r_mem[i_addr] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory target: valid/ready request, WAIT_CYCLES
// wait states, single-cycle response pulse with read data or write acknowledge
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;

  logic              w_access;
  logic [WORD_W-1:0] w_mem_rdata;

  // The access edge is the last WAIT cycle; only the latched request is used.
  assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_access && r_we),
    .i_byte  (r_byte),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_byte  <= bus.req_byte;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ST_RESP;
            if (r_we) begin
              r_rdata <= '0;
            end else if (r_byte) begin
              r_rdata <= {{(WORD_W-BYTE_W){1'b0}}, w_mem_rdata[BYTE_LANE_MSB:BYTE_LANE_LSB]};
            end else begin
              r_rdata <= w_mem_rdata;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with WAIT_CYCLES 0, 1 and 15
module tb_dmem_responder;
  import cpu_pkg::*;

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic        v   [3];
  logic        we  [3];
  logic        byt [3];
  logic [4:0]  ad  [3];
  logic [31:0] wd  [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [31:0] rdd [3];
  logic        prev_rv [3] = '{1'b0, 1'b0, 1'b0};

  dmem_if #(.ADDR_W(5)) bus0 ();
  dmem_if #(.ADDR_W(5)) bus1 ();
  dmem_if #(.ADDR_W(5)) bus2 ();

  assign bus0.req_valid = v[0];   assign bus1.req_valid = v[1];   assign bus2.req_valid = v[2];
  assign bus0.req_we    = we[0];  assign bus1.req_we    = we[1];  assign bus2.req_we    = we[2];
  assign bus0.req_byte  = byt[0]; assign bus1.req_byte  = byt[1]; assign bus2.req_byte  = byt[2];
  assign bus0.req_addr  = ad[0];  assign bus1.req_addr  = ad[1];  assign bus2.req_addr  = ad[2];
  assign bus0.req_wdata = wd[0];  assign bus1.req_wdata = wd[1];  assign bus2.req_wdata = wd[2];
  assign rdy[0] = bus0.req_ready; assign rdy[1] = bus1.req_ready; assign rdy[2] = bus2.req_ready;
  assign rv[0]  = bus0.rsp_valid; assign rv[1]  = bus1.rsp_valid; assign rv[2]  = bus2.rsp_valid;
  assign rdd[0] = bus0.rsp_rdata; assign rdd[1] = bus1.rsp_rdata; assign rdd[2] = bus2.rsp_rdata;

  dmem_responder #(.ADDR_W(5), .WAIT_CYCLES(0))  u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dmem_responder #(.ADDR_W(5), .WAIT_CYCLES(1))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  dmem_responder #(.ADDR_W(5), .WAIT_CYCLES(15)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    int idx;
    for (int k = 0; k < 3; k++) begin
      if (rv[k]) begin
        check($sformatf("rsp_width_dut%0d", k), 32'(prev_rv[k]), 32'd0);
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].dut == k) idx = i;
        end
        if (idx < 0) begin
          check($sformatf("rsp_unexpected_dut%0d", k), 32'd1, 32'd0);
        end else begin
          check($sformatf("rsp_rdata_dut%0d", k), rdd[k], exp_q[idx].data);
          check($sformatf("rsp_latency_dut%0d", k), 32'(cyc), 32'(exp_q[idx].due));
          exp_q.delete(idx);
        end
      end
      prev_rv[k] = rv[k];
    end
  end

  task automatic issue(input int k, input logic iwe, input logic ib, input logic [4:0] ia,
                       input logic [31:0] iwd, input logic [31:0] iexp);
    bit acc = 1'b0;
    we[k] = iwe; byt[k] = ib; ad[k] = ia; wd[k] = iwd; v[k] = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      if (rdy[k]) begin
        @(posedge clk); #1;
        acc  = 1'b1;
        v[k] = 1'b0;
        exp_q.push_back('{k, iexp, cyc + wait_of(k) + 1});
      end
    end
    v[k] = 1'b0;
    check($sformatf("accept_dut%0d", k), 32'(acc), 32'd1);
  endtask

  task automatic wr(input int k, input logic ib, input logic [4:0] ia, input logic [31:0] iwd);
    issue(k, 1'b1, ib, ia, iwd, 32'h0);
  endtask

  task automatic rd(input int k, input logic ib, input logic [4:0] ia, input logic [31:0] iexp);
    issue(k, 1'b0, ib, ia, 32'h0, iexp);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nacc;
    int last;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; we[k] = 1'b0; byt[k] = 1'b0; ad[k] = 5'd0; wd[k] = 32'h0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready",     32'(rdy[1]), 32'd1);
    check("reset_rsp_valid", 32'(rv[1]),  32'd0);
    check("reset_rdata",     rdd[1],      32'h0);
    check("reset_ready_w15", 32'(rdy[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    wr(1, 1'b0, 5'd3, 32'hDEADBEEF);
    rd(1, 1'b0, 5'd3, 32'hDEADBEEF);

    wr(1, 1'b0, 5'd7, 32'h11223344);
    wr(1, 1'b1, 5'd7, 32'h000000AB);
    rd(1, 1'b0, 5'd7, 32'hAB223344);
    rd(1, 1'b1, 5'd7, 32'h000000AB);

    wr(1, 1'b0, 5'd31, 32'hCAFEF00D);
    wr(1, 1'b0, 5'd0,  32'h00000000);
    rd(1, 1'b0, 5'd31, 32'hCAFEF00D);
    rd(1, 1'b0, 5'd0,  32'h00000000);

    wr(0, 1'b0, 5'd5, 32'hA5A5A5A5);
    rd(0, 1'b0, 5'd5, 32'hA5A5A5A5);
    rd(0, 1'b1, 5'd5, 32'h000000A5);
    wr(2, 1'b0, 5'd6, 32'h0F0F1234);
    rd(2, 1'b0, 5'd6, 32'h0F0F1234);
    rd(2, 1'b1, 5'd6, 32'h0000000F);
    drain();

    // Continuous valid with an address that changes every cycle.
    nacc = 0;
    last = -1;
    we[1] = 1'b1; byt[1] = 1'b0; v[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ad[1] = 5'(i);
      wd[1] = 32'h100 + 32'(i);
      @(negedge clk);
      if (rdy[1]) begin
        exp_q.push_back('{1, 32'h0, cyc + 1 + 2});
        if (last >= 0) check("accept_spacing", 32'(cyc + 1 - last), 32'd4);
        last = cyc + 1;
        nacc++;
      end
      @(posedge clk); #1;
    end
    v[1] = 1'b0;
    check("accept_count", 32'(nacc), 32'd4);
    rd(1, 1'b0, 5'd4,  32'h00000104);
    rd(1, 1'b0, 5'd12, 32'h0000010C);
    rd(1, 1'b0, 5'd5,  32'h00000000);
    drain();

    // Reset lands in the last WAIT cycle of a write to address 9.
    we[1] = 1'b1; byt[1] = 1'b0; ad[1] = 5'd9; wd[1] = 32'h55AA55AA; v[1] = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_ready",     32'(rdy[1]), 32'd1);
    check("abort_rsp_valid", 32'(rv[1]),  32'd0);
    check("abort_rdata",     rdd[1],      32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd(1, 1'b0, 5'd9, 32'h00000000);
    rd(1, 1'b0, 5'd3, 32'h00000000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multicycle CPU: the target end of the CPU's load/store path. It accepts one word- or byte-wide read or write request through a valid/ready handshake, inserts a parameterizable number of wait states, and returns a single-cycle response pulse carrying read data or a write acknowledge. It sits between the CPU datapath (address from the ALU result, store data from the R2 register) and the on-chip data storage, replacing the zero-wait combinational memory model.

## Interface
- `ADDR_W`, default 5: word-address width. Depth = 2**ADDR_W words of 32 bits.
- `WAIT_CYCLES`, default 1: extra wait states per access, legal range 0..15.
- `clk` input 1: single clock. All state updates occur on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_byte` input 1: 1 = byte access (store type or load type), 0 = word access.
- `req_addr` input ADDR_W: word address.
- `req_wdata` input 32: store data.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: read data, or zero for a write.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `we`, `byte`, `addr`, and `wdata`; load `cnt`=WAIT_CYCLES; go to WAIT.
  - WAIT: `req_ready`=0. If `cnt`!=0, decrement it. If `cnt`==0, perform the access on this edge and go to RESP. WAIT lasts exactly WAIT_CYCLES+1 cycles.
  - RESP: `rsp_valid`=1 for one cycle, then unconditionally return to IDLE. `req_ready`=0.
- Access semantics, using the latched request only:
  - Word write: `mem[addr]` <= `wdata`.
  - Byte write: `mem[addr][31:24]` <= `wdata[7:0]`. Bits [23:0] are preserved.
  - Word read: `rsp_rdata` <= `mem[addr]`.
  - Byte read: `rsp_rdata` <= {24'd0, `mem[addr][31:24]`}.
  - Any write: `rsp_rdata` <= 0.
- `rsp_rdata` holds its value outside RESP until the next access.
- Inputs sampled while not in IDLE are ignored. The initiator must hold its request until it sees `req_ready`.
- `cnt` width is 4 bits, sized for WAIT_CYCLES up to 15. Addresses need no range check because depth is exactly 2**ADDR_W.

## Timing
- Reset (`rst`=0, asynchronous):
  - State = IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `cnt`=0.
  - All memory words are cleared to 0.
- Reset during WAIT or RESP abandons the pending transaction. No write commits and no `rsp_valid` pulse is produced.
- Latency: accept at edge E0, access at edge E0+WAIT_CYCLES+1, and `rsp_valid` high in the cycle after that edge. `req_ready` returns at edge E0+WAIT_CYCLES+2.
- Throughput: one transaction per WAIT_CYCLES+3 cycles. With WAIT_CYCLES=1, that is 4 cycles.
- Read after write to the same address in back-to-back transactions returns the new data.
- A `req_valid` asserted during RESP is not accepted. It can be accepted at the first IDLE edge.

## Structure
- Shared package `cpu_pkg`:
  - State enum `dmem_state_t`: {IDLE, WAIT, RESP}.
  - `WORD_W`=32.
  - `BYTE_LANE_MSB`=31 and `BYTE_LANE_LSB`=24, so load-type and store-type share one lane definition with the CPU datapath.
- One sub-module, `dmem_array`:
  - Register-file storage of 2**ADDR_W x 32 bits.
  - Asynchronous clear.
  - Synchronous write-enable plus a byte-lane select.
  - Combinational read port.
  - The FSM, counter, and response register stay in `dmem_responder`.

## Test plan
- Reset: hold `rst`=0 mid-WAIT, then release. Expect `req_ready`=1, `rsp_valid`=0, and `rsp_rdata`=0. A follow-up read of the aborted write address returns 0x00000000.
- Word write/read with WAIT_CYCLES=1:
  - Write 0xDEADBEEF to address 3. Expect `rsp_valid` 2 cycles after accept with `rsp_rdata`=0.
  - Read address 3. Expect 0xDEADBEEF.
- Byte lanes:
  - Word-write 0x11223344 to address 7, then byte-write `wdata`=0x000000AB to address 7.
  - Word read returns 0xAB223344. Byte read returns 0x000000AB.
- Handshake: hold `req_valid` high continuously with changing addresses. Only requests seen in IDLE are accepted. With WAIT_CYCLES=1, there is one accept every 4 cycles and exactly one `rsp_valid` pulse per accept.
- Wait-state extremes:
  - WAIT_CYCLES=0: `rsp_valid` comes 1 cycle after accept.
  - WAIT_CYCLES=15: `rsp_valid` comes 16 cycles after accept.
  - In both cases `rsp_valid` is never wider than one cycle.
- Address wrap: write 0xCAFEF00D to address 31 and 0x0 to address 0 with ADDR_W=5. Reading back addresses 31 and 0 returns each value independently.
